dp_mem_responder: RTL

//  Responder end of datapath_cache_if: services the pipeline's instruction and data requests.

---
 rtl/dp_mem_responder_pkg.sv | 17 +
 rtl/dp_mem_responder_if.sv | 40 ++++
 rtl/dp_mem_responder.sv | 119 +++++++++++
 3 files changed

// File: rtl/dp_mem_responder_pkg.sv
// Shared types for the datapath-side memory responder.
// Holds the word type, bus widths and the responder FSM state encoding.
package dp_mem_responder_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        IREQ,
        DREQ,
        DONE
    } respstate_t;

endpackage

// File: rtl/dp_mem_responder_if.sv
// Datapath-to-responder and responder-to-RAM signal bundle.
// slave: the responder. master: the datapath plus the RAM model.
interface dp_mem_responder_if;
    import dp_mem_responder_pkg::*;

    logic                imemREN;
    logic [ADDR_W-1:0]   imemaddr;
    logic                dmemREN;
    logic                dmemWEN;
    logic [ADDR_W-1:0]   dmemaddr;
    word_t               dmemstore;
    logic                halt;
    logic                ihit;
    logic                dhit;
    word_t               imemload;
    word_t               dmemload;
    logic                ramREN;
    logic                ramWEN;
    logic [ADDR_W-1:0]   ramaddr;
    word_t               ramstore;
    word_t               ramload;
    logic                ramready;

    modport slave (
        input  imemREN, imemaddr, dmemREN, dmemWEN,
        input  dmemaddr, dmemstore, halt,
        input  ramload, ramready,
        output ihit, dhit, imemload, dmemload,
        output ramREN, ramWEN, ramaddr, ramstore
    );

    modport master (
        output imemREN, imemaddr, dmemREN, dmemWEN,
        output dmemaddr, dmemstore, halt,
        output ramload, ramready,
        input  ihit, dhit, imemload, dmemload,
        input  ramREN, ramWEN, ramaddr, ramstore
    );

endinterface

// File: rtl/dp_mem_responder.sv
// Arbitrates instruction/data requests onto one RAM port; data wins.
// Define DP_MEM_IBUF_EN for a one-entry instruction buffer.
module dp_mem_responder
    import dp_mem_responder_pkg::*;
(
    input  logic               CLK,
    input  logic               nRST,
    dp_mem_responder_if.slave  bus
);

    respstate_t          r_state;
    respstate_t          w_next;
    logic [ADDR_W-1:0]   r_addr;
    word_t               r_store;
    logic                r_wr;
    logic                r_isd;
    word_t               r_imemload;
    word_t               r_dmemload;

    logic                w_dreq;
    logic                w_ireq;
    logic                w_bhit;

    assign w_dreq = bus.dmemREN | bus.dmemWEN;
    assign w_ireq = bus.imemREN & ~bus.halt;

`ifdef DP_MEM_IBUF_EN
    logic                r_bvalid;
    logic [ADDR_W-1:0]   r_btag;
    word_t               r_bword;

    assign w_bhit = r_bvalid & (r_btag == bus.imemaddr);

    // Invalidate on a store to the buffered address as it is accepted
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_bvalid <= 1'b0;
            r_btag   <= '0;
            r_bword  <= '0;
        end else if (r_state == IREQ && bus.ramready) begin
            r_bvalid <= 1'b1;
            r_btag   <= r_addr;
            r_bword  <= bus.ramload;
        end else if (r_state == IDLE && w_dreq && bus.dmemWEN
                     && bus.dmemaddr == r_btag) begin
            r_bvalid <= 1'b0;
        end
    end
`else
    assign w_bhit = 1'b0;
`endif

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_dreq)      w_next = DREQ;
                else if (w_ireq) w_next = w_bhit ? DONE : IREQ;
            end
            IREQ, DREQ: begin
                if (bus.ramready) w_next = DONE;
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_addr     <= '0;
            r_store    <= '0;
            r_wr       <= 1'b0;
            r_isd      <= 1'b0;
            r_imemload <= '0;
            r_dmemload <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_dreq) begin
                        r_addr  <= bus.dmemaddr;
                        r_store <= bus.dmemstore;
                        r_wr    <= bus.dmemWEN;
                        r_isd   <= 1'b1;
                    end else if (w_ireq) begin
                        r_addr  <= bus.imemaddr;
                        r_store <= '0;
                        r_wr    <= 1'b0;
                        r_isd   <= 1'b0;
`ifdef DP_MEM_IBUF_EN
                        if (w_bhit) r_imemload <= r_bword;
`endif
                    end
                end
                IREQ: begin
                    if (bus.ramready) r_imemload <= bus.ramload;
                end
                DREQ: begin
                    if (bus.ramready && !r_wr) r_dmemload <= bus.ramload;
                end
                default: ;
            endcase
        end
    end

    assign bus.ihit     = (r_state == DONE) & ~r_isd;
    assign bus.dhit     = (r_state == DONE) &  r_isd;
    assign bus.ramREN   = (r_state == IREQ) | ((r_state == DREQ) & ~r_wr);
    assign bus.ramWEN   = (r_state == DREQ) & r_wr;
    assign bus.ramaddr  = r_addr;
    assign bus.ramstore = r_store;
    assign bus.imemload = r_imemload;
    assign bus.dmemload = r_dmemload;

endmodule
